dmem_responder: RTL and testbench

//   Data-memory responder at the far end of the decoder's readMem_en/writeMem_en strobes (lw/sw).

---
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the datapath and the data-memory responder.
// Ports: read_en/write_en/addr/wdata (request), req_ready/done/rdata/rdata_valid/err (response).
interface dmem_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          read_en;
    logic          write_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          req_ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          err;

    modport master (
        output read_en, write_en, addr, wdata,
        input  req_ready, done, rdata, rdata_valid, err
    );

    modport slave (
        input  read_en, write_en, addr, wdata,
        output req_ready, done, rdata, rdata_valid, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per request, answered after LAT clocks.
// Ports: clk, rst_n (async active-low), bus (dmem_if.slave: request in, response out).
module dmem_responder #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("dmem_responder: LAT must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          load_q;
    logic          err_q;

    logic          idle;
    logic          accept;
    logic          illegal;
    logic          commit;
    logic          op_load;
    logic [AW-1:0] tgt_addr;
    logic [DW-1:0] tgt_wdata;

    assign idle    = (state == IDLE);
    assign accept  = idle && (bus.read_en || bus.write_en);
    assign illegal = bus.read_en && bus.write_en;

    // With LAT==1 the array is touched on the accept edge itself, so the
    // live bus fields are used; otherwise the latched copies are used.
    assign tgt_addr  = idle ? bus.addr    : addr_q;
    assign tgt_wdata = idle ? bus.wdata   : wdata_q;
    assign op_load   = idle ? bus.read_en : load_q;

    // The edge that enters RESP is the one that completes the access.
    assign commit = (state_nx == RESP) && (state != RESP);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    if (LAT == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            err_q <= accept && illegal;
            if (accept && !illegal) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                load_q  <= bus.read_en;
            end
            if (commit && op_load) begin
                rdata_q <= mem[tgt_addr];
            end
        end
    end

    // Array is not reset; rst_n gating keeps a request seen during reset
    // from committing.
    always_ff @(posedge clk) begin
        if (rst_n && commit && !op_load) begin
            mem[tgt_addr] <= tgt_wdata;
        end
    end

    assign bus.req_ready   = idle;
    assign bus.done        = (state == RESP);
    assign bus.rdata_valid = (state == RESP) && load_q;
    assign bus.err         = err_q;
    assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT 2, 1, 15) share one request stream.
// A timing/array model checks every cycle; directed literals pin the model.
module tb_dmem_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       read_en, write_en;
    logic [7:0] addr, wdata;

    int n_chk  = 0;
    int n_fail = 0;
    int n      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) n <= n + 1;

    dmem_if #(.DW(8), .AW(8)) b0 ();
    dmem_if #(.DW(8), .AW(8)) b1 ();
    dmem_if #(.DW(8), .AW(8)) b2 ();

    assign b0.read_en = read_en;  assign b0.write_en = write_en;
    assign b0.addr    = addr;     assign b0.wdata    = wdata;
    assign b1.read_en = read_en;  assign b1.write_en = write_en;
    assign b1.addr    = addr;     assign b1.wdata    = wdata;
    assign b2.read_en = read_en;  assign b2.write_en = write_en;
    assign b2.addr    = addr;     assign b2.wdata    = wdata;

    dmem_responder #(.DW(8), .AW(8), .LAT(2))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    dmem_responder #(.DW(8), .AW(8), .LAT(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dmem_responder #(.DW(8), .AW(8), .LAT(15)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    logic [2:0] o_ready, o_done, o_rv, o_err;
    logic [7:0] o_rdata [3];
    assign o_ready = {b2.req_ready, b1.req_ready, b0.req_ready};
    assign o_done  = {b2.done, b1.done, b0.done};
    assign o_rv    = {b2.rdata_valid, b1.rdata_valid, b0.rdata_valid};
    assign o_err   = {b2.err, b1.err, b0.err};
    assign o_rdata[0] = b0.rdata;
    assign o_rdata[1] = b1.rdata;
    assign o_rdata[2] = b2.rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accept at edge k completes at edge k+LAT-1 and the responder
    // is free again from edge k+LAT on.
    int         lat [3] = '{2, 1, 15};
    bit         pend [3];
    bit         p_load [3];
    logic [7:0] p_addr [3];
    logic [7:0] p_wd [3];
    int         done_edge [3];
    int         free_edge [3] = '{0, 0, 0};
    int         err_edge [3] = '{-1, -1, -1};
    bit         rdy_prev [3] = '{1, 1, 1};
    logic [7:0] m_rdata [3] = '{0, 0, 0};
    bit         m_known [3] = '{1, 1, 1};
    logic [7:0] mm [3][256];
    bit         wr [3][256];

    always @(posedge clk or negedge rst_n) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            bit e_done, e_ready, e_err, e_rv;
            if (!rst_n) begin
                pend[i]      = 0;
                free_edge[i] = 0;
                err_edge[i]  = -1;
                rdy_prev[i]  = 1;
                m_rdata[i]   = 8'h00;
                m_known[i]   = 1;
                e_done  = 0;
                e_ready = 1;
                e_err   = 0;
                e_rv    = 0;
            end else begin
                if (rdy_prev[i] && (read_en || write_en)) begin
                    if (read_en && write_en) begin
                        err_edge[i] = n;
                    end else begin
                        pend[i]      = 1;
                        p_load[i]    = read_en;
                        p_addr[i]    = addr;
                        p_wd[i]      = wdata;
                        done_edge[i] = n + lat[i] - 1;
                        free_edge[i] = n + lat[i];
                    end
                end
                e_done = pend[i] && (n == done_edge[i]);
                e_rv   = e_done && p_load[i];
                if (e_done) begin
                    if (p_load[i]) begin
                        m_known[i] = wr[i][p_addr[i]];
                        m_rdata[i] = mm[i][p_addr[i]];
                    end else begin
                        mm[i][p_addr[i]] = p_wd[i];
                        wr[i][p_addr[i]] = 1;
                    end
                    pend[i] = 0;
                end
                e_ready = (n >= free_edge[i]);
                e_err   = (n == err_edge[i]);
                rdy_prev[i] = e_ready;
            end
            chk($sformatf("i%0d req_ready", i), 32'(o_ready[i]), 32'(e_ready));
            chk($sformatf("i%0d done", i), 32'(o_done[i]), 32'(e_done));
            chk($sformatf("i%0d rdata_valid", i), 32'(o_rv[i]), 32'(e_rv));
            chk($sformatf("i%0d err", i), 32'(o_err[i]), 32'(e_err));
            if (m_known[i]) begin
                chk($sformatf("i%0d rdata", i), 32'(o_rdata[i]), 32'(m_rdata[i]));
            end
        end
    end

    task automatic set_req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        read_en  = r;
        write_en = w;
        addr     = a;
        wdata    = d;
    endtask

    task automatic clr();
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int c);
        @(negedge clk);
        clr();
        repeat (c) @(posedge clk);
    endtask

    initial begin
        int k;
        int c0, c1, c2;
        rst_n = 1'b0;
        clr();
        addr  = 8'h00;
        wdata = 8'h00;
        #1;
        chk("rst ready", 32'(b0.req_ready), 32'd1);
        chk("rst rdata", 32'(b0.rdata), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // store then load, LAT=2
        set_req(0, 1, 8'h10, 8'hA5);
        step();
        chk("st busy", 32'(b0.req_ready), 32'd0);
        @(negedge clk); clr();
        step();
        chk("st done", 32'(b0.done), 32'd1);
        chk("st no rvalid", 32'(b0.rdata_valid), 32'd0);
        step();
        chk("st idle", 32'(b0.req_ready), 32'd1);
        set_req(1, 0, 8'h10, 8'h00);
        step();
        chk("ld busy", 32'(b0.req_ready), 32'd0);
        @(negedge clk); clr();
        step();
        chk("ld done", 32'(b0.done), 32'd1);
        chk("ld rvalid", 32'(b0.rdata_valid), 32'd1);
        chk("ld rdata", 32'(b0.rdata), 32'hA5);
        step();
        chk("ld rvalid pulse", 32'(b0.rdata_valid), 32'd0);
        chk("ld rdata hold", 32'(b0.rdata), 32'hA5);

        // illegal request
        idle(20);
        set_req(0, 1, 8'h20, 8'h33);
        step();
        idle(20);
        set_req(1, 1, 8'h20, 8'hFF);
        step();
        chk("ill err", 32'(b0.err), 32'd1);
        chk("ill ready", 32'(b0.req_ready), 32'd1);
        @(negedge clk); clr();
        step();
        chk("ill err pulse", 32'(b0.err), 32'd0);
        chk("ill no done", 32'(b0.done), 32'd0);
        idle(20);
        set_req(1, 0, 8'h20, 8'h00);
        step();
        @(negedge clk); clr();
        step();
        chk("ill old data", 32'(b0.rdata), 32'h33);

        // load held across an in-flight store to the same address
        idle(20);
        set_req(0, 1, 8'h30, 8'h77);
        step();
        set_req(1, 0, 8'h30, 8'h00);
        k = 0;
        while (k < 20) begin
            step();
            if (b0.rdata_valid) break;
            k++;
        end
        chk("raw found", 32'(k), 32'd3);
        chk("raw rdata", 32'(b0.rdata), 32'h77);
        idle(20);

        // reset during WAIT drops the store
        set_req(0, 1, 8'h40, 8'h11);
        step();
        idle(20);
        set_req(0, 1, 8'h40, 8'h5A);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", 32'(b0.req_ready), 32'd1);
        chk("mid rst done", 32'(b0.done), 32'd0);
        chk("mid rst rvalid", 32'(b0.rdata_valid), 32'd0);
        chk("mid rst err", 32'(b0.err), 32'd0);
        chk("mid rst rdata", 32'(b0.rdata), 32'h00);
        @(negedge clk);
        clr();
        rst_n = 1'b1;
        c0 = 0;
        for (int j = 0; j < 5; j++) begin
            step();
            c0 += int'(b0.done);
        end
        chk("rst no done", 32'(c0), 32'd0);
        idle(20);
        set_req(1, 0, 8'h40, 8'h00);
        step();
        @(negedge clk); clr();
        step();
        chk("rst old data", 32'(b0.rdata), 32'h11);
        idle(20);

        // back-to-back requests held for 64 edges
        c0 = 0; c1 = 0; c2 = 0;
        for (int j = 0; j < 64; j++) begin
            set_req(j[0], ~j[0], 8'h80 + 8'(j % 8), 8'(j * 7));
            step();
            c0 += int'(b0.done);
            c1 += int'(b1.done);
            c2 += int'(b2.done);
        end
        chk("b2b lat2 dones", 32'(c0), 32'd21);
        chk("b2b lat1 dones", 32'(c1), 32'd32);
        chk("b2b lat15 dones", 32'(c2), 32'd4);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
